alu_share_arbiter: RTL
======================

# alu_share_arbiter

Sequential front end that shares one 8-bit four-operand ALU between two requesters. It arbitrates and captures one request's operands and opcode, then computes the result in a registered execute stage. The result and zero flag are held until the consumer accepts them. It sits between the two issuing units and the ALU datapath; only one operation is in flight at a time.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i has an operation pending
- req_ready  out  2  bit i: requester i's operation is accepted this cycle
- req_opcode  in  8  requester i opcode in bits [4i+3:4i]
- req_a, req_b, req_c, req_d  in  16 each  requester i operand in bits [8i+7:8i]
- req_sel  in  2  bit i: requester i select bit
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  1  index of the requester that owns the result
- rsp_result  out  8  ALU result
- rsp_zero  out  1  high when rsp_result == 0
- busy  out  1  high in EXEC or RESP
- ops_done  out  8  count of completed responses, wraps modulo 256

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - Grant g is computed combinationally from req_valid.
  - req_ready[g] = 1 only in IDLE, only for the granted requester, and only when req_valid[g] = 1.
  - When req_valid[g] & req_ready[g], latch the opcode, a, b, c, d and sel slices of requester g plus the id g, then go to EXEC.
- **EXEC** (exactly 1 cycle)
  - The ALU operates on the latched operands.
  - rsp_result, rsp_zero and rsp_id are registered at the end of the cycle.
  - Go to RESP.
- **RESP**
  - rsp_valid = 1, and all rsp_* outputs are held stable.
  - On rsp_ready = 1: increment ops_done and return to IDLE.
- **Opcode semantics**
  - All arithmetic is 8-bit, modulo 256, with carries and borrows discarded.
  - 0 and 7: a+b+c+d.
  - 1: a−b.
  - 2: a&b.
  - 3: a|b.
  - 4: a^b.
  - 5: ~a.
  - 6: sel ? a+c : b+d.
  - 8–15: result 0.
- **Arbitration**
  - Only one requester valid: that requester wins.
  - Both requesters valid: decided by the arbitration mode (see Configuration).
  - A pointer last_grant is updated on every accept.
- Requests that arrive while busy are not accepted. Requesters must hold req_valid and their operands stable until req_ready.

## Timing
- Latency: accept at edge N → rsp_valid high from cycle N+2.
- Minimum occupancy is 3 cycles per operation, so peak throughput is one operation per 3 cycles.
- Back-to-back: a response accepted at cycle M allows a new accept at cycle M+1, the IDLE cycle.
- rsp_valid is never asserted in the same cycle as any req_ready.
- Reset values:
  - FSM = IDLE
  - req_ready = 0 while rst is asserted
  - rsp_valid = 0
  - rsp_id = 0
  - rsp_result = 0x00
  - rsp_zero = 1
  - busy = 0
  - ops_done = 0
  - last_grant = 1
- Reset mid-operation, in EXEC or RESP: the in-flight operation is dropped. ops_done is not incremented and no response is ever presented.
- If rsp_ready is held high continuously, each response lasts exactly 1 cycle.
- ops_done wraps from 0xFF to 0x00.

## Configuration
- Macro: ALU_SHARE_ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are valid, grant the one ≠ last_grant. After reset, requester 0 wins the first tie.
- Undefined: fixed priority, requester 0 always wins ties. last_grant is still tracked but unused.

## Test plan
- Single request: requester 0, opcode 0, a=0x10, b=0x20, c=0x30, d=0x40, rsp_ready=1.
  - Required: rsp_valid at N+2 with rsp_result=0xA0, rsp_zero=0, rsp_id=0, ops_done=1.
- Wrap and zero flag: requester 1, opcode 1, a=0x05, b=0x05 → rsp_result=0x00, rsp_zero=1. Then opcode 0 with a=b=c=d=0x80 → 0x00, rsp_zero=1.
- Contention: both requesters valid continuously, rsp_ready=1.
  - With the macro defined: grants alternate 0,1,0,1.
  - With it undefined: grants are 0,0,0,0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - Required: rsp_* stable, req_ready=00, busy=1. On rsp_ready=1, return to IDLE next cycle.
- Opcode coverage:
  - opcode 6, sel=1, a=0x01, c=0x02 → 0x03.
  - sel=0, b=0x04, d=0x05 → 0x09.
  - opcode 5, a=0xF0 → 0x0F.
  - opcode 9 → 0x00.
- Reset mid-operation: assert rst in EXEC.
  - Required: next cycle rsp_valid=0, busy=0, ops_done unchanged. After 255 completed ops plus 1 more, ops_done=0x00.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Request and response bundle between the two issuing units, the shared ALU
// front end, and the result consumer.
//
// Handshake rules: a transfer on either channel happens on a rising clock edge
// where valid and ready are both high. A producer holds valid and its payload
// stable until that edge. ready may depend combinationally on valid, valid
// never depends on ready.
interface alu_share_arbiter_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [7:0]  req_opcode;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [15:0] req_c;
   logic [15:0] req_d;
   logic [1:0]  req_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [7:0]  rsp_result;
   logic        rsp_zero;

   // ALU front end side
   modport slave (
      input  req_valid, req_opcode, req_a, req_b, req_c, req_d, req_sel, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
   );

   // Requesters plus consumer side
   modport master (
      output req_valid, req_opcode, req_a, req_b, req_c, req_d, req_sel, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one 8-bit four-operand ALU between two requesters. One operation is
// in flight at a time: IDLE accepts, EXEC computes into registers, RESP holds
// the result until the consumer takes it.
//
// Build option: define ALU_SHARE_ARB_ROUND_ROBIN_EN to alternate grants when
// both requesters are valid; otherwise requester 0 wins every tie.
// state_dbg and last_grant_dbg expose the FSM state and arbitration pointer.
module alu_share_arbiter (
   input  logic                clk,
   input  logic                rst,
   alu_share_arbiter_if.slave  bus,
   output logic                busy,
   output logic [7:0]          ops_done,
   output logic [1:0]          state_dbg,
   output logic                last_grant_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        grant;
   logic        accept;
   logic [1:0]  ready;

   logic [3:0]  op_q;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic [7:0]  c_q;
   logic [7:0]  d_q;
   logic        sel_q;
   logic        id_q;
   logic        last_grant;

   logic [7:0]  result_q;
   logic        zero_q;
   logic        rsp_id_q;
   logic [7:0]  ops_q;
   logic [7:0]  alu_y;

   // Pick the requester to serve; ties resolved by the build-time policy
   always_comb begin
      grant = 1'b0;
      case (bus.req_valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11: begin
`ifdef ALU_SHARE_ARB_ROUND_ROBIN_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
         end
         default: grant = 1'b0;
      endcase
   end

   // Next state and accept strobe; ready is forced low while in reset
   always_comb begin
      state_d = state_q;
      ready   = 2'b00;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid[grant]) begin
               ready[grant] = 1'b1;
               accept       = 1'b1;
               state_d      = EXEC;
            end
         end
         EXEC:    state_d = RESP;
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         ready  = 2'b00;
         accept = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ALU on the latched operands; all arithmetic wraps at 8 bits
   always_comb begin
      alu_y = 8'h00;
      case (op_q)
         4'd0, 4'd7: alu_y = a_q + b_q + c_q + d_q;
         4'd1:       alu_y = a_q - b_q;
         4'd2:       alu_y = a_q & b_q;
         4'd3:       alu_y = a_q | b_q;
         4'd4:       alu_y = a_q ^ b_q;
         4'd5:       alu_y = ~a_q;
         4'd6:       alu_y = sel_q ? (a_q + c_q) : (b_q + d_q);
         default:    alu_y = 8'h00;
      endcase
   end

   // Operand capture, result register, completion counter and grant pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= 4'h0;
         a_q        <= 8'h00;
         b_q        <= 8'h00;
         c_q        <= 8'h00;
         d_q        <= 8'h00;
         sel_q      <= 1'b0;
         id_q       <= 1'b0;
         last_grant <= 1'b1;
         result_q   <= 8'h00;
         zero_q     <= 1'b1;
         rsp_id_q   <= 1'b0;
         ops_q      <= 8'h00;
      end else begin
         if (accept) begin
            op_q       <= grant ? bus.req_opcode[7:4] : bus.req_opcode[3:0];
            a_q        <= grant ? bus.req_a[15:8]     : bus.req_a[7:0];
            b_q        <= grant ? bus.req_b[15:8]     : bus.req_b[7:0];
            c_q        <= grant ? bus.req_c[15:8]     : bus.req_c[7:0];
            d_q        <= grant ? bus.req_d[15:8]     : bus.req_d[7:0];
            sel_q      <= grant ? bus.req_sel[1]      : bus.req_sel[0];
            id_q       <= grant;
            last_grant <= grant;
         end
         if (state_q == EXEC) begin
            result_q <= alu_y;
            zero_q   <= (alu_y == 8'h00);
            rsp_id_q <= id_q;
         end
         if ((state_q == RESP) && bus.rsp_ready) begin
            ops_q <= ops_q + 8'd1;
         end
      end
   end

   assign bus.req_ready   = ready;
   assign bus.rsp_valid   = (state_q == RESP);
   assign bus.rsp_id      = rsp_id_q;
   assign bus.rsp_result  = result_q;
   assign bus.rsp_zero    = zero_q;
   assign busy            = (state_q != IDLE);
   assign ops_done        = ops_q;
   assign state_dbg       = state_q;
   assign last_grant_dbg  = last_grant;

endmodule
